iccm_boot_loader: RTL and testbench
===================================

Name: iccm_boot_loader

Overview:
- Upstream feeder of the instruction memory. Takes a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word into the ICCM at consecutive word addresses starting at 0.
- Holds the core in reset until an end-of-program marker word arrives or memory fills. It then releases the core and hands the ICCM address/read path back to the fetch unit.

Parameters:
- DataWidth, 32, ICCM word width; fixed at 32 (4 bytes per word).
- AddrWidth, 15, ICCM word-address width; depth = 2**AddrWidth.
- EndWord, 32'h00000FFF, marker word that terminates loading; never written to memory.

Ports:
- brq_clk  input  1  system clock, rising edge.
- brq_rst  input  1  asynchronous, active-high reset.
- i_rx_valid  input  1  one-cycle strobe: i_rx_byte holds a new received byte.
- i_rx_byte  input  8  received byte.
- o_rx_ready  output  1  loader can accept a byte this cycle.
- o_iccm_addr  output  AddrWidth  ICCM write word address.
- o_iccm_write  output  1  ICCM write enable, one-cycle pulse.
- o_iccm_wdata  output  DataWidth  ICCM write data.
- o_load_busy  output  1  high while loading; muxes ICCM address/read to loader and holds core reset.
- o_load_done  output  1  sticky: program loaded, core may run.
- o_overflow  output  1  sticky: memory filled before EndWord was received.

Behaviour:
- Reset (async, brq_rst=1) values:
  - state=COLLECT, byte count=0, word address=0.
  - o_iccm_write=0, o_iccm_wdata=0, o_iccm_addr=0.
  - o_load_busy=1, o_load_done=0, o_overflow=0, o_rx_ready=1.
- States: COLLECT, WRITE, DONE.
- COLLECT:
  - o_rx_ready=1.
  - On i_rx_valid, the byte goes into lane [8*cnt+7:8*cnt] of the assembly register (first byte = bits [7:0]); cnt increments.
  - On the 4th byte (cnt=3), the completed word is compared to EndWord:
    - equal -> DONE, no write;
    - otherwise -> WRITE, with o_iccm_wdata = completed word registered.
- WRITE:
  - Lasts exactly one cycle. o_iccm_write=1, o_iccm_addr=current address, o_rx_ready=0.
  - Next cycle: o_iccm_write=0.
  - If address==DEPTH-1: set o_overflow=1 and go to DONE.
  - Otherwise: address+1, cnt=0, back to COLLECT.
- Latency: the 4th byte's i_rx_valid cycle is followed by one registered cycle with o_iccm_write high.
- A byte with i_rx_valid in WRITE is dropped; the UART inter-byte gap (≥10 bit times) guarantees this cannot occur in practice. The bench checks the drop.
- DONE (terminal until reset):
  - o_load_busy=0, o_load_done=1, o_rx_ready=0, o_iccm_write=0.
  - All further bytes are ignored.
- Address never wraps: the WRITE at DEPTH-1 ends loading.
- Partial word (cnt 1..3) is never written; a reset mid-word discards it.
- Reset in any state returns to the reset values above; memory contents are untouched.
- o_iccm_addr holds its last value in COLLECT/DONE.

Optional Feature:
- Macro: ICCM_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output port o_checksum, output, DataWidth: modulo-2**32 sum of every word written (EndWord excluded).
  - Cleared on reset; updated in the WRITE cycle; frozen in DONE.
  - Lets the host compare the loaded image over a debug path.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Bytes 13,05,00,00 then FF,0F,00,00 -> one write at addr 0 with data 32'h00000513; o_load_done=1, o_load_busy=0 one cycle after the 8th byte; o_overflow=0.
- Three words A1B2C3D4, 11223344, DEADBEEF (little-endian bytes) then EndWord -> writes at addr 0,1,2 with matching data; exactly 3 write pulses, each 1 cycle wide.
- AddrWidth=2 build, 5 non-marker words -> writes at addr 0..3 only; o_overflow=1, o_load_done=1 after 4th write; 5th word ignored, no write.
- Two bytes sent, brq_rst asserted asynchronously mid-cycle, then full word 00000093 -> all outputs at reset values immediately; the word is written at addr 0 with data 32'h00000093 (stale bytes discarded).
- i_rx_valid pulsed in the WRITE cycle -> byte dropped, o_rx_ready=0 that cycle; next 4 bytes form the next word correctly.
- ICCM_LOADER_CHECKSUM_EN build, words 00000001, FFFFFFFF, 00000010 then EndWord -> o_checksum=32'h00000010 (wrap-around); stays constant when extra bytes arrive in DONE.

Source files
------------

// File: rtl/iccm_boot_loader_if.sv
// Byte-stream and ICCM-write bundle for the ICCM boot loader.
// The loader side uses the master modport; the UART/ICCM side uses the slave modport.
interface iccm_boot_loader_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 15
);
  logic                 i_rx_valid;
  logic [7:0]           i_rx_byte;
  logic                 o_rx_ready;
  logic [AddrWidth-1:0] o_iccm_addr;
  logic                 o_iccm_write;
  logic [DataWidth-1:0] o_iccm_wdata;
  logic                 o_load_busy;
  logic                 o_load_done;
  logic                 o_overflow;

  modport master (
    input  i_rx_valid, i_rx_byte,
    output o_rx_ready, o_iccm_addr, o_iccm_write, o_iccm_wdata,
    output o_load_busy, o_load_done, o_overflow
  );

  modport slave (
    output i_rx_valid, i_rx_byte,
    input  o_rx_ready, o_iccm_addr, o_iccm_write, o_iccm_wdata,
    input  o_load_busy, o_load_done, o_overflow
  );
endinterface

// File: rtl/iccm_boot_loader.sv
// ICCM boot loader: assembles little-endian words from UART bytes, writes them to
// consecutive ICCM word addresses from 0, and holds the core until EndWord arrives
// or memory fills.
// Optional running checksum of written words: define ICCM_LOADER_CHECKSUM_EN.
module iccm_boot_loader #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 15,
  parameter logic [DataWidth-1:0] EndWord   = 32'h0000_0FFF
) (
  input logic                brq_clk,
  input logic                brq_rst,
  iccm_boot_loader_if.master bus
`ifdef ICCM_LOADER_CHECKSUM_EN
  ,
  output logic [DataWidth-1:0] o_checksum
`endif
);

  typedef enum logic [1:0] {StCollect, StWrite, StDone} state_e;

  localparam logic [AddrWidth-1:0] LastAddr = '1;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [DataWidth-1:0] asm_q, asm_d;
  logic [AddrWidth-1:0] addr_q, addr_d;           // next address to write
  logic [AddrWidth-1:0] iccm_addr_q, iccm_addr_d; // address shown on the port
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 ovf_q, ovf_d;

  // Next-state logic: byte assembly, marker detection, address advance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    addr_d      = addr_q;
    iccm_addr_d = iccm_addr_q;
    wdata_d     = wdata_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      StCollect: begin
        if (bus.i_rx_valid) begin
          asm_d[{cnt_q, 3'b000} +: 8] = bus.i_rx_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (asm_d == EndWord) begin
              state_d = StDone;
            end else begin
              wdata_d     = asm_d;
              iccm_addr_d = addr_q;
              state_d     = StWrite;
            end
          end
        end
      end
      StWrite: begin
        // Bytes arriving here are dropped; the address never wraps.
        if (addr_q == LastAddr) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + AddrWidth'(1);
          cnt_d   = 2'd0;
          state_d = StCollect;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q     <= StCollect;
      cnt_q       <= 2'd0;
      asm_q       <= '0;
      addr_q      <= '0;
      iccm_addr_q <= '0;
      wdata_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      iccm_addr_q <= iccm_addr_d;
      wdata_q     <= wdata_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.o_rx_ready   = (state_q == StCollect);
  assign bus.o_iccm_write = (state_q == StWrite);
  assign bus.o_iccm_addr  = iccm_addr_q;
  assign bus.o_iccm_wdata = wdata_q;
  assign bus.o_load_busy  = (state_q != StDone);
  assign bus.o_load_done  = (state_q == StDone);
  assign bus.o_overflow   = ovf_q;

`ifdef ICCM_LOADER_CHECKSUM_EN
  logic [DataWidth-1:0] checksum_q, checksum_d;

  // Accumulate each word as it is written; frozen once loading ends.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StWrite) begin
      checksum_d = checksum_q + wdata_q;
    end
  end

  // Checksum register.
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign o_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Directed, table-driven bench for iccm_boot_loader (default and AddrWidth=2 builds).
module tb_iccm_boot_loader;

  typedef struct {
    logic        vld;
    logic [7:0]  b;
    logic        wr;
    logic [14:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   aux_writes = 0;
  logic [31:0] w;
  vec_t vecs[$];

  always #5 clk = ~clk;

  iccm_boot_loader_if #(.DataWidth(32), .AddrWidth(15)) bus ();
  iccm_boot_loader_if #(.DataWidth(32), .AddrWidth(2))  bus2 ();

`ifdef ICCM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] checksum2;
`endif

  iccm_boot_loader #(.DataWidth(32), .AddrWidth(15), .EndWord(32'h0000_0FFF)) u_dut (
    .brq_clk    (clk),
    .brq_rst    (rst),
    .bus        (bus)
`ifdef ICCM_LOADER_CHECKSUM_EN
    ,
    .o_checksum (checksum)
`endif
  );

  iccm_boot_loader #(.DataWidth(32), .AddrWidth(2), .EndWord(32'h0000_0FFF)) u_dut_small (
    .brq_clk    (clk),
    .brq_rst    (rst),
    .bus        (bus2)
`ifdef ICCM_LOADER_CHECKSUM_EN
    ,
    .o_checksum (checksum2)
`endif
  );

  // Count write-enable cycles of the small instance.
  always @(negedge clk) begin
    if (!rst && bus2.o_iccm_write) aux_writes++;
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string name, input logic wr, input logic [14:0] a,
                            input logic [31:0] wd, input logic rdy, input logic busy,
                            input logic done, input logic ovf);
    logic [51:0] act, exp;
    act = {bus.o_iccm_write, bus.o_iccm_addr, bus.o_iccm_wdata,
           bus.o_rx_ready, bus.o_load_busy, bus.o_load_done, bus.o_overflow};
    exp = {wr, a, wd, rdy, busy, done, ovf};
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wr=%b addr=%h wd=%h rdy/busy/done/ovf=%b%b%b%b, expected wr=%b addr=%h wd=%h rdy/busy/done/ovf=%b%b%b%b",
               name, act[51], act[50:36], act[35:4], act[3], act[2], act[1], act[0],
               wr, a, wd, rdy, busy, done, ovf);
    end
  endtask

  function automatic void add(input logic vld, input logic [7:0] b, input logic wr,
                              input logic [14:0] a, input logic [31:0] wd, input logic rdy,
                              input logic busy, input logic done, input logic ovf);
    vec_t v;
    v.vld = vld; v.b = b; v.wr = wr; v.addr = a; v.wd = wd;
    v.rdy = rdy; v.busy = busy; v.done = done; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // Four little-endian bytes of wd_new, written at wa; pa/pw are the port values held
  // before the write; the final entry is the WRITE cycle with inputs (fv, fb).
  function automatic void add_word(input logic [31:0] wd_new, input logic [14:0] wa,
                                   input logic [14:0] pa, input logic [31:0] pw,
                                   input logic fv, input logic [7:0] fb);
    for (int k = 0; k < 3; k++) add(1'b1, wd_new[8*k +: 8], 1'b0, pa, pw, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, wd_new[31:24], 1'b1, wa, wd_new, 1'b0, 1'b1, 1'b0, 1'b0);
    add(fv, fb, 1'b0, wa, wd_new, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  // Drive each entry for one cycle and check the outputs after the edge.
  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.i_rx_valid = vecs[i].vld;
      bus.i_rx_byte  = vecs[i].b;
      @(posedge clk);
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      check_main($sformatf("%s[%0d]", name, i), vecs[i].wr, vecs[i].addr, vecs[i].wd,
                 vecs[i].rdy, vecs[i].busy, vecs[i].done, vecs[i].ovf);
    end
    vecs.delete();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_aux(input logic [7:0] b);
    bus2.i_rx_valid = 1'b1;
    bus2.i_rx_byte  = b;
    @(posedge clk);
    @(negedge clk);
    bus2.i_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_rx_valid  = 1'b0;
    bus.i_rx_byte   = 8'h00;
    bus2.i_rx_valid = 1'b0;
    bus2.i_rx_byte  = 8'h00;
    #3;
    check_main("reset", 1'b0, 15'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("reset_small", {bus2.o_iccm_write, bus2.o_iccm_addr, bus2.o_rx_ready,
                              bus2.o_load_busy, bus2.o_load_done, bus2.o_overflow},
              {1'b0, 2'd0, 4'b1100});
`ifdef ICCM_LOADER_CHECKSUM_EN
    check_val("reset_checksum", checksum, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // One word, then the marker.
    add(1'b1, 8'h13, 1'b0, 15'd0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h05, 1'b0, 15'd0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b1, 15'd0, 32'h513, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 15'd0, 32'h513, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 15'd0, 32'h513, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h0F, 1'b0, 15'd0, 32'h513, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd0, 32'h513, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd0, 32'h513, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'h5A, 1'b0, 15'd0, 32'h513, 1'b0, 1'b0, 1'b1, 1'b0);
    run_table("single");

    // Three words then the marker; extra byte in DONE ignored.
    pulse_reset();
    add_word(32'hA1B2C3D4, 15'd0, 15'd0, 32'h0,        1'b0, 8'h00);
    add_word(32'h11223344, 15'd1, 15'd0, 32'hA1B2C3D4, 1'b0, 8'h00);
    add_word(32'hDEADBEEF, 15'd2, 15'd1, 32'h11223344, 1'b0, 8'h00);
    add(1'b1, 8'hFF, 1'b0, 15'd2, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h0F, 1'b0, 15'd2, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd2, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'h12, 1'b0, 15'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    run_table("three");

    // Byte during WRITE is dropped; the next four bytes form the next word.
    pulse_reset();
    add_word(32'h04030201, 15'd0, 15'd0, 32'h0,        1'b1, 8'h77);
    add_word(32'h44332211, 15'd1, 15'd0, 32'h04030201, 1'b0, 8'h00);
    // Two stale bytes before an asynchronous reset.
    add(1'b1, 8'hAA, 1'b0, 15'd1, 32'h44332211, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hBB, 1'b0, 15'd1, 32'h44332211, 1'b1, 1'b1, 1'b0, 1'b0);
    run_table("drop");

    #2 rst = 1'b1;
    #1 check_main("async_rst", 1'b0, 15'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    add_word(32'h00000093, 15'd0, 15'd0, 32'h0, 1'b0, 8'h00);
    run_table("after_rst");

`ifdef ICCM_LOADER_CHECKSUM_EN
    pulse_reset();
    add_word(32'h00000001, 15'd0, 15'd0, 32'h0,        1'b0, 8'h00);
    add_word(32'hFFFFFFFF, 15'd1, 15'd0, 32'h00000001, 1'b0, 8'h00);
    add_word(32'h00000010, 15'd2, 15'd1, 32'hFFFFFFFF, 1'b0, 8'h00);
    add(1'b1, 8'hFF, 1'b0, 15'd2, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h0F, 1'b0, 15'd2, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd2, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 15'd2, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    run_table("csum");
    check_val("checksum", checksum, 32'h00000010);
    add(1'b1, 8'h01, 1'b0, 15'd2, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'h02, 1'b0, 15'd2, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    run_table("csum_done");
    check_val("checksum_frozen", checksum, 32'h00000010);
`endif

    // Small memory: four writes fill it, the fifth word is ignored.
    aux_writes = 0;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      w = 32'hC0DE_0000 + k;
      for (int j = 0; j < 4; j++) send_aux(w[8*j +: 8]);
      if (k < 4) begin
        check_val($sformatf("small_write%0d", k),
                  {bus2.o_iccm_write, bus2.o_iccm_addr, bus2.o_iccm_wdata},
                  {1'b1, 2'(k), w});
      end
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("small_state%0d", k),
                {bus2.o_iccm_write, bus2.o_overflow, bus2.o_load_done,
                 bus2.o_load_busy, bus2.o_rx_ready},
                (k >= 3) ? 64'b01100 : 64'b00011);
    end
    check_val("small_addr_hold", bus2.o_iccm_addr, 64'd3);
    check_val("small_write_count", aux_writes, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
